// File: rtl/seq_det_pkg.sv
// Shared types, default parameters and config legality helper for the
// windowed serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned WIN_W_DEF   = 16;

  function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Overlapping pattern matcher: history shift register, fill counter and a
// length-masked compare producing a combinational (Mealy) match.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               d,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  // Newest bit sits at window[0], so the compare lines up with pat[len-1:0].
  assign window = {hist, d};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign match = shift_en
              && (({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len})
              && (((window ^ pat) & mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= window[MAX_LEN-2:0];
      if (fill != LEN_W'(MAX_LEN - 1)) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_window_ctrl.sv
// Window controller: sequences one detection window of win_len valid bits,
// counts matches with saturation and flags rejected configurations.
module seq_det_window_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned WIN_W   = WIN_W_DEF,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [WIN_W-1:0]   win_len,
  input  logic               d,
  input  logic               d_valid,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               sat,
  output logic               cfg_err
);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   bit_cnt;
  logic               cfg_ok, accept, reject, run_bit, last_bit;

  assign cfg_ok   = len_ok(32'(cfg_len), MAX_LEN) && (win_len != '0);
  assign accept   = (state != RUN) && start && cfg_ok;
  assign reject   = (state != RUN) && start && !cfg_ok;
  assign run_bit  = (state == RUN) && d_valid && !abort;
  assign last_bit = run_bit && (bit_cnt == win_q - WIN_W'(1));

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .shift_en (run_bit),
    .d        (d),
    .pat      (pat_q),
    .len      (len_q),
    .match    (match)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (accept) state_nxt = RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Counter holds at all-ones; a further match only sets the sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      win_q     <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      sat       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= reject;
      if (accept) begin
        pat_q     <= cfg_pat;
        len_q     <= cfg_len;
        win_q     <= win_len;
        bit_cnt   <= '0;
        match_cnt <= '0;
        sat       <= 1'b0;
      end else if (run_bit) begin
        bit_cnt <= bit_cnt + WIN_W'(1);
        if (match) begin
          if (&match_cnt) sat <= 1'b1;
          else            match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_window_ctrl.sv
// Self-checking bench: two DUT widths share stimulus and are compared each
// cycle against a list-of-bits reference model, plus directed spot checks.
module tb_seq_det_window_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, d, d_valid;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic [15:0] win_len;

  logic       busy8, done8, match8, sat8, err8;
  logic [7:0] cnt8;
  logic       busy2, done2, match2, sat2, err2;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_window_ctrl #(.MAX_LEN(8), .CNT_W(8), .WIN_W(16)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .win_len(win_len), .d(d), .d_valid(d_valid),
    .busy(busy8), .done(done8), .match(match8), .match_cnt(cnt8),
    .sat(sat8), .cfg_err(err8)
  );

  seq_det_window_ctrl #(.MAX_LEN(8), .CNT_W(2), .WIN_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .win_len(win_len), .d(d), .d_valid(d_valid),
    .busy(busy2), .done(done2), .match(match2), .match_cnt(cnt2),
    .sat(sat2), .cfg_err(err2)
  );

  // Reference model: the window is the list of bits accepted so far.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int   mst = M_IDLE;
  bit   known = 0;
  bit   mbits[$];
  int   mlen = 0, mwin = 0, mcount = 0, nmatch = 0;
  bit [7:0] mpat = '0;
  bit   merr = 0;

  function automatic bit model_match(input bit dd);
    int sz;
    bit b;
    sz = mbits.size();
    if (sz + 1 < mlen) return 0;
    for (int k = 0; k < mlen; k++) begin
      b = (k == 0) ? dd : mbits[sz - k];
      if (b != mpat[k]) return 0;
    end
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setcfg(input logic [7:0] p, input logic [3:0] l, input logic [15:0] w);
    cfg_pat = p;
    cfg_len = l;
    win_len = w;
  endtask

  task automatic cyc(input logic r, input logic s, input logic a, input logic dd, input logic v);
    bit em;
    bit ok;
    int c8, c2;
    rst = r; start = s; abort = a; d = dd; d_valid = v;
    @(negedge clk);
    #1;
    if (known) begin
      em = (mst == M_RUN) && v && !a && model_match(dd);
      c8 = (nmatch > 255) ? 255 : nmatch;
      c2 = (nmatch > 3) ? 3 : nmatch;
      chk("busy8",  32'(busy8),  32'(mst == M_RUN));
      chk("done8",  32'(done8),  32'(mst == M_DONE));
      chk("busy2",  32'(busy2),  32'(mst == M_RUN));
      chk("done2",  32'(done2),  32'(mst == M_DONE));
      chk("match8", 32'(match8), 32'(em));
      chk("match2", 32'(match2), 32'(em));
      chk("cnt8",   32'(cnt8),   32'(c8));
      chk("sat8",   32'(sat8),   32'(nmatch > 255));
      chk("cnt2",   32'(cnt2),   32'(c2));
      chk("sat2",   32'(sat2),   32'(nmatch > 3));
      chk("err8",   32'(err8),   32'(merr));
      chk("err2",   32'(err2),   32'(merr));
    end
    @(posedge clk);
    if (r) begin
      known = 1; mst = M_IDLE; merr = 0; nmatch = 0; mcount = 0; mbits.delete();
    end else begin
      ok = (cfg_len >= 1) && (cfg_len <= 8) && (win_len != 0);
      merr = 0;
      if (mst != M_RUN) begin
        if (s && ok) begin
          mst = M_RUN; mbits.delete(); nmatch = 0; mcount = 0;
          mpat = cfg_pat; mlen = int'(cfg_len); mwin = int'(win_len);
        end else if (s) begin
          merr = 1;
        end
      end else if (a) begin
        mst = M_IDLE;
      end else if (v) begin
        if (model_match(dd)) nmatch++;
        mbits.push_back(dd);
        mcount++;
        if (mcount == mwin) mst = M_DONE;
      end
    end
    #1;
  endtask

  initial begin
    logic [6:0] s1;
    logic [4:0] s2;
    logic [2:0] s3;
    logic [3:0] s4;
    logic r, s, a, v;

    setcfg('0, '0, '0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_cnt",  32'(cnt8),  32'd0);
    chk("rst_err",  32'(err8),  32'd0);

    // 1101 over 1101101: matches on bits 4 and 7
    setcfg(8'b1101, 4'd4, 16'd7);
    cyc(0, 1, 0, 0, 0);
    chk("tp1_busy", 32'(busy8), 32'd1);
    s1 = 7'b1101101;
    for (int i = 6; i >= 0; i--) cyc(0, 0, 0, s1[i], 1);
    chk("tp1_done", 32'(done8), 32'd1);
    chk("tp1_cnt",  32'(cnt8),  32'd2);

    // 101 with gaps, started back-to-back from DONE
    setcfg(8'b101, 4'd3, 16'd5);
    cyc(0, 1, 0, 0, 0);
    chk("tp2_busy", 32'(busy8), 32'd1);
    chk("tp2_clr",  32'(cnt8),  32'd0);
    s2 = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 0, 0, s2[i], 1);
      cyc(0, 0, 0, 1'($urandom), 0);
    end
    chk("tp2_cnt", 32'(cnt8), 32'd2);

    // single-bit pattern: 2-bit counter saturates
    setcfg(8'b1, 4'd1, 16'd5);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1);
    chk("tp3_cnt2", 32'(cnt2), 32'd3);
    chk("tp3_sat2", 32'(sat2), 32'd1);
    chk("tp3_cnt8", 32'(cnt8), 32'd5);
    chk("tp3_done", 32'(done2), 32'd1);

    // illegal configurations
    setcfg(8'b1, 4'd0, 16'd5);
    cyc(0, 1, 0, 0, 0);
    chk("tp4_err",  32'(err8),  32'd1);
    chk("tp4_busy", 32'(busy8), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("tp4_pulse", 32'(err8), 32'd0);
    setcfg(8'b1, 4'd3, 16'd0);
    cyc(0, 1, 0, 0, 0);
    setcfg(8'b1, 4'd9, 16'd4);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("tp4_keep", 32'(cnt8), 32'd5);

    // abort after three bits; then start+abort together
    setcfg(8'b1101, 4'd4, 16'd7);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 1);
    chk("tp5_busy", 32'(busy8), 32'd0);
    chk("tp5_done", 32'(done8), 32'd0);
    chk("tp5_cnt",  32'(cnt8),  32'd0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 1, 1, 1);
    chk("tp5_sa", 32'(busy8), 32'd0);

    // reset mid-window, then full window and restart from DONE
    cyc(0, 1, 0, 0, 0);
    s4 = 4'b1101;
    for (int i = 3; i >= 0; i--) cyc(0, 0, 0, s4[i], 1);
    chk("tp6_pre", 32'(cnt8), 32'd1);
    cyc(1, 0, 0, 1, 1);
    chk("tp6_cnt",  32'(cnt8),  32'd0);
    chk("tp6_busy", 32'(busy8), 32'd0);
    setcfg(8'b011, 4'd3, 16'd3);
    cyc(0, 1, 0, 0, 0);
    s3 = 3'b011;
    for (int i = 2; i >= 0; i--) cyc(0, 0, 0, s3[i], 1);
    chk("tp6_done", 32'(done8), 32'd1);
    cyc(0, 1, 0, 0, 0);
    chk("tp6_rerun", 32'(busy8), 32'd1);
    chk("tp6_clr",   32'(cnt8),  32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom % 300) == 0;
      s = ($urandom % 8) == 0;
      a = ($urandom % 40) == 0;
      v = ($urandom % 4) != 0;
      if (s) setcfg(8'($urandom), 4'($urandom_range(0, 9)), 16'($urandom_range(0, 30)));
      cyc(r, s, a, 1'($urandom), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
